hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central stall/flush/forwarding controller for the 5-stage pipeline (F, D, E, M, W).
- Consumes register addresses and control bits from the ID, EX, MEM and WB pipeline registers, plus the data-memory request/ready handshake.
- Produces per-stage stall and flush enables and the EX-stage operand forwarding selects.
- Sequences multi-cycle memory waits with a bounded timeout; a timeout is a fatal error state.

Parameters:
MEM_TIMEOUT, 64, max cycles the FSM stays in MEM_WAIT before entering ERR (must be >= 2)
CNT_W, 32, width of performance counters (used only with HAZARD_PERF_EN)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous, active-high reset
rs1D_i  in  5  rs1 of instruction in D
rs2D_i  in  5  rs2 of instruction in D
rs1E_i  in  5  rs1 of instruction in E (from ID/EX register)
rs2E_i  in  5  rs2 of instruction in E
rdE_i  in  5  destination of instruction in E
RegWriteE_i  in  1  E instruction writes a register
LoadE_i  in  1  E instruction is a load (WriteSrc selects memory)
branchTakenE_i  in  1  branch/jump/ret redirect resolved in E
rdM_i  in  5  destination in M
RegWriteM_i  in  1  M instruction writes a register
rdW_i  in  5  destination in W
RegWriteW_i  in  1  W instruction writes a register
memReq_i  in  1  M-stage data memory access active
memReady_i  in  1  data memory completes access this cycle
StallF_o  out  1  hold PC
StallD_o  out  1  hold IF/ID register
StallE_o  out  1  hold ID/EX register
StallM_o  out  1  hold EX/MEM register
FlushD_o  out  1  clear IF/ID register to bubble
FlushE_o  out  1  clear ID/EX register to bubble
ForwardA_o  out  2  E operand 1 select: 00 register file, 10 M result, 01 W result
ForwardB_o  out  2  E operand 2 select, same encoding
memErr_o  out  1  sticky memory timeout flag
stallCnt_o  out  CNT_W  cycles with StallF_o=1 (HAZARD_PERF_EN)
flushCnt_o  out  CNT_W  cycles with FlushE_o=1 (HAZARD_PERF_EN)

Behaviour:
- State register: RUN=2'b00, MEM_WAIT=2'b01, ERR=2'b10. Timeout counter is $clog2(MEM_TIMEOUT) bits.
- Reset (rst_i=1 at edge): state is RUN, counter is 0, memErr_o is 0, perf counters are 0.
  - While rst_i=1, outputs are forced to FlushD_o=1, FlushE_o=1, all stalls 0, forwards 00.
- Stall/flush/forward outputs are combinational from inputs and the current state (zero latency). State, counter and memErr_o are registered.
- Forwarding is always active, except outputs are forced to 00 during reset.
  - ForwardA_o=10 if RegWriteM_i and rdM_i!=0 and rdM_i==rs1E_i.
  - Otherwise 01 if RegWriteW_i and rdW_i!=0 and rdW_i==rs1E_i.
  - Otherwise 00. M has priority over W.
  - ForwardB_o is identical using rs2E_i.
- Memory stall (memStall) = (state==RUN and memReq_i and !memReady_i) or (state==MEM_WAIT and !memReady_i) or (state==ERR).
  - memStall asserts StallF/D/E/M_o=1 and FlushD_o=FlushE_o=0.
  - Memory stall has highest priority: branch and load-use are suppressed while it is active.
- Branch flush: if !memStall and branchTakenE_i, then FlushD_o=1 and FlushE_o=1, with no stalls. A load-use hit in the same cycle is ignored, because D is discarded.
- Load-use: if !memStall, !branchTakenE_i, LoadE_i, RegWriteE_i, rdE_i!=0, and (rdE_i==rs1D_i or rdE_i==rs2D_i):
  - StallF_o=1, StallD_o=1, FlushE_o=1, for exactly one cycle.
  - The cycle after, the load is in M and the match clears naturally.
- RUN transitions:
  - memReq_i and !memReady_i: go to MEM_WAIT, counter<=1.
  - memReq_i and memReady_i (single-cycle access): stay in RUN, no stall.
- MEM_WAIT transitions:
  - memReady_i: go to RUN, counter<=0. The release cycle has no memory stall; a pending branch/load-use applies in this cycle.
  - !memReady_i and counter==MEM_TIMEOUT-1: go to ERR, memErr_o<=1.
  - Otherwise counter increments.
  - Memory stall therefore spans at most MEM_TIMEOUT cycles before ERR.
- ERR: all stalls held high, memErr_o=1; exits only via rst_i. memReq_i and memReady_i are ignored.
- Reset asserted mid-MEM_WAIT or in ERR returns to RUN on the next edge.

Optional Feature:
- HAZARD_PERF_EN defined:
  - stallCnt_o increments each non-reset cycle with StallF_o=1.
  - flushCnt_o increments each non-reset cycle with FlushE_o=1.
  - Both counters saturate at all-ones and clear on reset.
- Not defined: the ports remain present but are tied to 0, and no counter flops are inferred.

Test Plan:
- rdM=5,RegWriteM=1,rdW=5,RegWriteW=1,rs1E=5,rs2E=0 -> ForwardA=10, ForwardB=00; with RegWriteM=0 -> ForwardA=01.
- LoadE=1,RegWriteE=1,rdE=7,rs2D=7 -> one cycle of StallF=StallD=FlushE=1; next cycle (rdE=0 bubble) all 0; with rdE=0 -> no stall.
- branchTakenE=1 together with load-use match -> FlushD=FlushE=1, StallF=StallD=0.
- memReq=1, memReady low 3 cycles then high -> stalls=1 for 3 cycles, state returns to RUN, release cycle stalls=0; branchTakenE held throughout -> flush only in release cycle.
- MEM_TIMEOUT=4, memReq=1, memReady stuck 0 -> stalls for 4 cycles, then ERR, memErr_o=1 and stalls stay high; rst_i pulse -> RUN, memErr_o=0.
- HAZARD_PERF_EN: 2 load-use stalls + 3 memory stall cycles + 1 branch -> stallCnt_o=5, flushCnt_o=3; without the macro both read 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall, flush and forwarding control for a 5-stage pipeline (F, D, E, M, W).
//
// Stall, flush and forward outputs are combinational from the inputs and the current state.
// The memory-wait FSM (RUN / MEM_WAIT / ERR) and the sticky timeout flag are registered.
//
// Optional build macro: HAZARD_PERF_EN
//   defined   -> saturating stall/flush cycle counters drive stallCnt_o / flushCnt_o
//   undefined -> both counter ports are tied to zero and no counter flops exist
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    // Source and destination registers from the pipeline registers
    input  logic [4:0]       rs1D_i,
    input  logic [4:0]       rs2D_i,
    input  logic [4:0]       rs1E_i,
    input  logic [4:0]       rs2E_i,
    input  logic [4:0]       rdE_i,
    input  logic             RegWriteE_i,
    input  logic             LoadE_i,
    input  logic             branchTakenE_i,
    input  logic [4:0]       rdM_i,
    input  logic             RegWriteM_i,
    input  logic [4:0]       rdW_i,
    input  logic             RegWriteW_i,
    // Data memory handshake
    input  logic             memReq_i,
    input  logic             memReady_i,
    // Pipeline control
    output logic             StallF_o,
    output logic             StallD_o,
    output logic             StallE_o,
    output logic             StallM_o,
    output logic             FlushD_o,
    output logic             FlushE_o,
    output logic [1:0]       ForwardA_o,
    output logic [1:0]       ForwardB_o,
    output logic             memErr_o,
    output logic [CNT_W-1:0] stallCnt_o,
    output logic [CNT_W-1:0] flushCnt_o
);

    // Wait counter is wide enough to hold MEM_TIMEOUT-1, the last cycle before ERR.
    localparam int unsigned TmoW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TmoW-1:0] TmoOne  = TmoW'(1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(MEM_TIMEOUT - 1);

    // Forwarding select encodings
    localparam logic [1:0] FwdReg = 2'b00;
    localparam logic [1:0] FwdW   = 2'b01;
    localparam logic [1:0] FwdM   = 2'b10;

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StMemWait = 2'b01,
        StErr     = 2'b10
    } state_e;

    state_e          state_q;
    logic [TmoW-1:0] tmo_cnt_q;
    logic            mem_err_q;

    logic mem_stall;
    logic load_use;

    // Pick the youngest in-flight producer of rs; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] rd_m, input logic we_m,
                                           input logic [4:0] rd_w, input logic we_w);
        logic [1:0] sel;
        sel = FwdReg;
        if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            sel = FwdM;
        end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            sel = FwdW;
        end
        return sel;
    endfunction

    // Hazard detection terms shared by the output decode
    always_comb begin
        mem_stall = 1'b0;
        unique case (state_q)
            StRun:     mem_stall = memReq_i && !memReady_i;
            StMemWait: mem_stall = !memReady_i;
            StErr:     mem_stall = 1'b1;
            default:   mem_stall = 1'b1;
        endcase

        load_use = LoadE_i && RegWriteE_i && (rdE_i != 5'd0) &&
                   ((rdE_i == rs1D_i) || (rdE_i == rs2D_i));
    end

    // Output decode: reset bubbles, then memory stall > branch flush > load-use interlock
    always_comb begin
        StallF_o   = 1'b0;
        StallD_o   = 1'b0;
        StallE_o   = 1'b0;
        StallM_o   = 1'b0;
        FlushD_o   = 1'b0;
        FlushE_o   = 1'b0;
        ForwardA_o = FwdReg;
        ForwardB_o = FwdReg;

        if (rst_i) begin
            FlushD_o = 1'b1;
            FlushE_o = 1'b1;
        end else begin
            ForwardA_o = fwd_sel(rs1E_i, rdM_i, RegWriteM_i, rdW_i, RegWriteW_i);
            ForwardB_o = fwd_sel(rs2E_i, rdM_i, RegWriteM_i, rdW_i, RegWriteW_i);

            if (mem_stall) begin
                // Freeze the whole front of the pipe; W keeps draining.
                StallF_o = 1'b1;
                StallD_o = 1'b1;
                StallE_o = 1'b1;
                StallM_o = 1'b1;
            end else if (branchTakenE_i) begin
                // D holds a wrong-path instruction, so a load-use hit on it is moot.
                FlushD_o = 1'b1;
                FlushE_o = 1'b1;
            end else if (load_use) begin
                // Hold F/D one cycle and inject a bubble behind the load.
                StallF_o = 1'b1;
                StallD_o = 1'b1;
                FlushE_o = 1'b1;
            end
        end
    end

    // Memory-wait FSM with bounded timeout and sticky error flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StRun;
            tmo_cnt_q <= '0;
            mem_err_q <= 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (memReq_i && !memReady_i) begin
                        state_q   <= StMemWait;
                        tmo_cnt_q <= TmoOne;
                    end
                end
                StMemWait: begin
                    if (memReady_i) begin
                        state_q   <= StRun;
                        tmo_cnt_q <= '0;
                    end else if (tmo_cnt_q == TmoLast) begin
                        state_q   <= StErr;
                        mem_err_q <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TmoOne;
                    end
                end
                StErr: begin
                    // Only reset leaves ERR.
                    mem_err_q <= 1'b1;
                end
                default: begin
                    state_q   <= StErr;
                    mem_err_q <= 1'b1;
                end
            endcase
        end
    end

    assign memErr_o = mem_err_q;

`ifdef HAZARD_PERF_EN
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Saturating counts of front-end stall cycles and E-stage bubble cycles
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (StallF_o && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CntOne;
            end
            if (FlushE_o && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CntOne;
            end
        end
    end

    assign stallCnt_o = stall_cnt_q;
    assign flushCnt_o = flush_cnt_q;
`else
    assign stallCnt_o = '0;
    assign flushCnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT=4).
// Expected counter values follow HAZARD_PERF_EN when the bench is built with it.
module tb_hazard_ctrl;

    localparam int unsigned Tmo  = 4;
    localparam int unsigned CntW = 32;

`ifdef HAZARD_PERF_EN
    localparam logic [31:0] ExpStallMid = 32'd2;
    localparam logic [31:0] ExpFlushMid = 32'd2;
    localparam logic [31:0] ExpStall    = 32'd5;
    localparam logic [31:0] ExpFlush    = 32'd3;
`else
    localparam logic [31:0] ExpStallMid = 32'd0;
    localparam logic [31:0] ExpFlushMid = 32'd0;
    localparam logic [31:0] ExpStall    = 32'd0;
    localparam logic [31:0] ExpFlush    = 32'd0;
`endif

    // ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE}
    localparam logic [31:0] CtlIdle  = 32'h00;
    localparam logic [31:0] CtlRst   = 32'h03;
    localparam logic [31:0] CtlMem   = 32'h3C;
    localparam logic [31:0] CtlBr    = 32'h03;
    localparam logic [31:0] CtlLoad  = 32'h31;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic RegWriteE, LoadE, branchTakenE, RegWriteM, RegWriteW, memReq, memReady;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE, memErr;
    logic [1:0] ForwardA, ForwardB;
    logic [CntW-1:0] stallCnt, flushCnt;

    int total = 0;
    int bad   = 0;

    logic [5:0] ctl;
    logic [3:0] fwd;
    assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE};
    assign fwd = {ForwardA, ForwardB};

    always #5 clk = ~clk;

    hazard_ctrl #(
        .MEM_TIMEOUT (Tmo),
        .CNT_W       (CntW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .rs1D_i         (rs1D),
        .rs2D_i         (rs2D),
        .rs1E_i         (rs1E),
        .rs2E_i         (rs2E),
        .rdE_i          (rdE),
        .RegWriteE_i    (RegWriteE),
        .LoadE_i        (LoadE),
        .branchTakenE_i (branchTakenE),
        .rdM_i          (rdM),
        .RegWriteM_i    (RegWriteM),
        .rdW_i          (rdW),
        .RegWriteW_i    (RegWriteW),
        .memReq_i       (memReq),
        .memReady_i     (memReady),
        .StallF_o       (StallF),
        .StallD_o       (StallD),
        .StallE_o       (StallE),
        .StallM_o       (StallM),
        .FlushD_o       (FlushD),
        .FlushE_o       (FlushE),
        .ForwardA_o     (ForwardA),
        .ForwardB_o     (ForwardB),
        .memErr_o       (memErr),
        .stallCnt_o     (stallCnt),
        .flushCnt_o     (flushCnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past a rising edge; inputs are then changed well away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0;
        rdE = '0; rdM = '0; rdW = '0;
        RegWriteE = 1'b0; LoadE = 1'b0; branchTakenE = 1'b0;
        RegWriteM = 1'b0; RegWriteW = 1'b0;
        memReq = 1'b0; memReady = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        // Forwarding match present during reset must still read 00.
        rdM = 5'd5; RegWriteM = 1'b1; rs1E = 5'd5;
        tick();
        chk("rst_ctl", 32'(ctl), CtlRst);
        chk("rst_fwd", 32'(fwd), 32'h0);
        chk("rst_err", 32'(memErr), 32'h0);
        chk("rst_scnt", stallCnt, 32'h0);
        chk("rst_fcnt", flushCnt, 32'h0);

        rst = 1'b0;
        clear_inputs();
        #1;
        chk("idle_ctl", 32'(ctl), CtlIdle);

        // Forwarding: M beats W, then W, then x0 never forwards, then operand B
        rdM = 5'd5; RegWriteM = 1'b1; rdW = 5'd5; RegWriteW = 1'b1; rs1E = 5'd5; rs2E = 5'd0;
        #1;
        chk("fwd_m_prio", 32'(fwd), 32'h8);
        RegWriteM = 1'b0;
        #1;
        chk("fwd_w", 32'(fwd), 32'h4);
        RegWriteM = 1'b1; rdM = 5'd0; rdW = 5'd0; rs1E = 5'd0;
        #1;
        chk("fwd_x0", 32'(fwd), 32'h0);
        rdM = 5'd9; RegWriteM = 1'b0; rdW = 5'd9; rs2E = 5'd9;
        #1;
        chk("fwd_b_w", 32'(fwd), 32'h1);
        RegWriteM = 1'b1;
        #1;
        chk("fwd_b_m", 32'(fwd), 32'h2);
        clear_inputs();

        // Load-use on rs2, then bubble cycle
        LoadE = 1'b1; RegWriteE = 1'b1; rdE = 5'd7; rs2D = 5'd7;
        #1;
        chk("lu_rs2", 32'(ctl), CtlLoad);
        tick();
        LoadE = 1'b0; RegWriteE = 1'b0; rdE = 5'd0;
        #1;
        chk("lu_bubble", 32'(ctl), CtlIdle);
        // Load-use on rs1
        LoadE = 1'b1; RegWriteE = 1'b1; rdE = 5'd3; rs1D = 5'd3; rs2D = 5'd0;
        #1;
        chk("lu_rs1", 32'(ctl), CtlLoad);
        tick();
        rdE = 5'd0; rs1D = 5'd0;
        #1;
        chk("lu_x0", 32'(ctl), CtlIdle);
        rdE = 5'd3; rs1D = 5'd3; RegWriteE = 1'b0;
        #1;
        chk("lu_nowrite", 32'(ctl), CtlIdle);
        // Branch wins over load-use (checked combinationally, withdrawn before the edge)
        RegWriteE = 1'b1; rdE = 5'd7; rs2D = 5'd7; rs1D = 5'd0; branchTakenE = 1'b1;
        #1;
        chk("br_over_lu", 32'(ctl), CtlBr);
        clear_inputs();
        #1;
        chk("idle2_ctl", 32'(ctl), CtlIdle);
        tick();
        chk("mid_scnt", stallCnt, ExpStallMid);
        chk("mid_fcnt", flushCnt, ExpFlushMid);

        // Multi-cycle access: 3 wait cycles, branch held throughout
        memReq = 1'b1; memReady = 1'b0; branchTakenE = 1'b1;
        #1;
        chk("mw_c0", 32'(ctl), CtlMem);
        tick();
        chk("mw_c1", 32'(ctl), CtlMem);
        tick();
        chk("mw_c2", 32'(ctl), CtlMem);
        tick();
        memReady = 1'b1;
        #1;
        chk("mw_release", 32'(ctl), CtlBr);
        tick();
        memReq = 1'b0; memReady = 1'b0; branchTakenE = 1'b0;
        #1;
        chk("mw_back_run", 32'(ctl), CtlIdle);
        chk("perf_scnt", stallCnt, ExpStall);
        chk("perf_fcnt", flushCnt, ExpFlush);
        memReq = 1'b1; memReady = 1'b1;
        #1;
        chk("single_cyc", 32'(ctl), CtlIdle);
        tick();
        memReq = 1'b0; memReady = 1'b0;
        #1;
        chk("single_run", 32'(ctl), CtlIdle);

        // Timeout: four stall cycles, then ERR
        memReq = 1'b1; memReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("tmo_stall%0d", i), 32'(ctl), CtlMem);
            chk($sformatf("tmo_noerr%0d", i), 32'(memErr), 32'h0);
            tick();
        end
        memReq = 1'b0; memReady = 1'b1;
        #1;
        chk("err_flag", 32'(memErr), 32'h1);
        chk("err_stall", 32'(ctl), CtlMem);
        tick();
        chk("err_hold", 32'(ctl), CtlMem);
        chk("err_sticky", 32'(memErr), 32'h1);
        rst = 1'b1;
        #1;
        chk("err_rst_ctl", 32'(ctl), CtlRst);
        tick();
        rst = 1'b0; memReady = 1'b0;
        #1;
        chk("err_cleared", 32'(memErr), 32'h0);
        chk("err_run", 32'(ctl), CtlIdle);
        chk("rst2_scnt", stallCnt, 32'h0);
        chk("rst2_fcnt", flushCnt, 32'h0);

        // Reset in the middle of MEM_WAIT
        memReq = 1'b1; memReady = 1'b0;
        tick();
        memReq = 1'b0;
        #1;
        chk("mw_no_req", 32'(ctl), CtlMem);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mw_rst_run", 32'(ctl), CtlIdle);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
